// File: rtl/control_pkg.sv
// Shared encodings for the multicycle MIPS control unit: state codes,
// ALU operation codes, instruction field values and datapath select constants.
package control_pkg;

  typedef enum logic [7:0] {
    S_RESET     = 8'd0,
    S_FETCH1    = 8'd1,
    S_FETCH2    = 8'd2,
    S_FETCH3    = 8'd3,
    S_DECODE    = 8'd4,
    S_R_EXEC    = 8'd5,
    S_R_WB      = 8'd6,
    S_MEM_ADDR  = 8'd7,
    S_LW_READ   = 8'd8,
    S_LW_WAIT   = 8'd9,
    S_LW_MDR    = 8'd10,
    S_LW_WB     = 8'd11,
    S_SW_WRITE  = 8'd12,
    S_BRANCH    = 8'd13,
    S_JUMP      = 8'd14,
    S_ADDI_EXEC = 8'd15,
    S_I_WB      = 8'd16,
    S_EXC_EPC   = 8'd17,
    S_EXC_PC    = 8'd18
  } state_t;

  localparam logic [2:0] ALU_LOAD = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b001;
  localparam logic [2:0] ALU_SUB  = 3'b010;
  localparam logic [2:0] ALU_AND  = 3'b011;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_EXC    = 2'b11;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic IORD_PC     = 1'b0;
  localparam logic IORD_ALUOUT = 1'b1;

endpackage

// File: rtl/control_unit.sv
// Multicycle MIPS control unit: Moore FSM with one state per datapath cycle,
// plus the conditional-branch PC_load term that depends on Zero.
module control_unit
  import control_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = 32'h0000_00FF
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [5:0] Opcode,
  input  logic [5:0] Funct,
  input  logic       Zero,
  input  logic       Overflow,
  output logic       PC_load,
  output logic       IorD,
  output logic       wr,
  output logic       IRWrite,
  output logic       MDR_load,
  output logic       AB_load,
  output logic       AluOut_load,
  output logic       EPC_load,
  output logic       RegWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUOp,
  output logic [1:0] PCSource,
  output logic [7:0] Estado
);

  // The datapath muxes this vector in when PCSource=11; a zero vector would
  // make an exception indistinguishable from a reset restart.
  if (EXC_VECTOR == 32'h0) begin : g_vector_check
    $error("EXC_VECTOR must differ from the reset PC");
  end

  state_t state;
  state_t next_state;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= S_RESET;
    else       state <= next_state;
  end

  assign Estado = state;

  always_comb begin
    next_state  = S_RESET;
    PC_load     = 1'b0;
    IorD        = IORD_PC;
    wr          = 1'b0;
    IRWrite     = 1'b0;
    MDR_load    = 1'b0;
    AB_load     = 1'b0;
    AluOut_load = 1'b0;
    EPC_load    = 1'b0;
    RegWrite    = 1'b0;
    RegDst      = 1'b0;
    MemtoReg    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = SRCB_B;
    ALUOp       = ALU_LOAD;
    PCSource    = PCSRC_ALU;
    case (state)
      S_RESET:  next_state = S_FETCH1;
      S_FETCH1: next_state = S_FETCH2;
      S_FETCH2: next_state = S_FETCH3;
      S_FETCH3: begin
        IRWrite    = 1'b1;
        ALUSrcB    = SRCB_FOUR;
        ALUOp      = ALU_ADD;
        PC_load    = 1'b1;
        PCSource   = PCSRC_ALU;
        next_state = S_DECODE;
      end
      S_DECODE: begin
        AB_load     = 1'b1;
        ALUSrcB     = SRCB_IMM_SH;
        ALUOp       = ALU_ADD;
        AluOut_load = 1'b1;
        case (Opcode)
          OP_RTYPE:      next_state = S_R_EXEC;
          OP_LW, OP_SW:  next_state = S_MEM_ADDR;
          OP_BEQ, OP_BNE: next_state = S_BRANCH;
          OP_J:          next_state = S_JUMP;
          OP_ADDI:       next_state = S_ADDI_EXEC;
          default:       next_state = S_EXC_EPC;
        endcase
      end
      S_R_EXEC: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_B;
        case (Funct)
          FN_ADD: begin
            ALUOp       = ALU_ADD;
            AluOut_load = 1'b1;
            next_state  = Overflow ? S_EXC_EPC : S_R_WB;
          end
          FN_SUB: begin
            ALUOp       = ALU_SUB;
            AluOut_load = 1'b1;
            next_state  = Overflow ? S_EXC_EPC : S_R_WB;
          end
          FN_AND: begin
            ALUOp       = ALU_AND;
            AluOut_load = 1'b1;
            next_state  = S_R_WB;
          end
          default: next_state = S_EXC_EPC;
        endcase
      end
      S_R_WB: begin
        RegWrite   = 1'b1;
        RegDst     = 1'b1;
        next_state = S_FETCH1;
      end
      S_MEM_ADDR: begin
        ALUSrcA     = 1'b1;
        ALUSrcB     = SRCB_IMM;
        ALUOp       = ALU_ADD;
        AluOut_load = 1'b1;
        next_state  = (Opcode == OP_LW) ? S_LW_READ : S_SW_WRITE;
      end
      S_LW_READ: begin
        IorD       = IORD_ALUOUT;
        next_state = S_LW_WAIT;
      end
      S_LW_WAIT: begin
        IorD       = IORD_ALUOUT;
        next_state = S_LW_MDR;
      end
      S_LW_MDR: begin
        IorD       = IORD_ALUOUT;
        MDR_load   = 1'b1;
        next_state = S_LW_WB;
      end
      S_LW_WB: begin
        RegWrite   = 1'b1;
        MemtoReg   = 1'b1;
        next_state = S_FETCH1;
      end
      S_SW_WRITE: begin
        IorD       = IORD_ALUOUT;
        wr         = 1'b1;
        next_state = S_FETCH1;
      end
      S_BRANCH: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = SRCB_B;
        ALUOp      = ALU_SUB;
        PCSource   = PCSRC_ALUOUT;
        // Mealy term: the branch decision uses Zero from this very cycle.
        PC_load    = (Opcode == OP_BNE) ? ~Zero : Zero;
        next_state = S_FETCH1;
      end
      S_JUMP: begin
        PCSource   = PCSRC_JUMP;
        PC_load    = 1'b1;
        next_state = S_FETCH1;
      end
      S_ADDI_EXEC: begin
        ALUSrcA     = 1'b1;
        ALUSrcB     = SRCB_IMM;
        ALUOp       = ALU_ADD;
        AluOut_load = 1'b1;
        next_state  = Overflow ? S_EXC_EPC : S_I_WB;
      end
      S_I_WB: begin
        RegWrite   = 1'b1;
        next_state = S_FETCH1;
      end
      S_EXC_EPC: begin
        ALUSrcB    = SRCB_FOUR;
        ALUOp      = ALU_SUB;
        EPC_load   = 1'b1;
        next_state = S_EXC_PC;
      end
      S_EXC_PC: begin
        PCSource   = PCSRC_EXC;
        PC_load    = 1'b1;
        next_state = S_FETCH1;
      end
      default: next_state = S_RESET;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: per-instruction expected state/output vectors are
// queued from the state table and compared cycle by cycle.
module tb_control_unit;

  localparam int W = 27;

  logic       clk;
  logic       rst;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       overflow;
  logic       pc_load, iord, wr, ir_write, mdr_load, ab_load, aluout_load;
  logic       epc_load, reg_write, reg_dst, mem_to_reg, alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] alu_op;
  logic [1:0] pc_source;
  logic [7:0] estado;

  logic [W-1:0] exp_q[$];
  logic [7:0]   seq_q[$];
  int           n_vec = 0;
  int           n_err = 0;

  control_unit #(.EXC_VECTOR(32'h0000_00FF)) dut (
    .Clk(clk), .Reset(rst), .Opcode(opcode), .Funct(funct),
    .Zero(zero), .Overflow(overflow),
    .PC_load(pc_load), .IorD(iord), .wr(wr), .IRWrite(ir_write),
    .MDR_load(mdr_load), .AB_load(ab_load), .AluOut_load(aluout_load),
    .EPC_load(epc_load), .RegWrite(reg_write), .RegDst(reg_dst),
    .MemtoReg(mem_to_reg), .ALUSrcA(alu_src_a), .ALUSrcB(alu_src_b),
    .ALUOp(alu_op), .PCSource(pc_source), .Estado(estado)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] dut_vec();
    return {estado, pc_load, iord, wr, ir_write, mdr_load, ab_load, aluout_load,
            epc_load, reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_source};
  endfunction

  // Expected outputs transcribed from the state table.
  function automatic logic [W-1:0] exp_vec(input logic [7:0] st, input logic [5:0] op,
                                           input logic [5:0] fn, input logic z);
    logic pl, id, w, irw, mdr, ab, alo, epc, rw, rd, m2r, sa;
    logic [1:0] sb, ps;
    logic [2:0] ao;
    {pl, id, w, irw, mdr, ab, alo, epc, rw, rd, m2r, sa} = '0;
    sb = 2'b00; ps = 2'b00; ao = 3'b000;
    case (st)
      8'd3:  begin irw = 1; sb = 2'b01; ao = 3'b001; pl = 1; end
      8'd4:  begin ab = 1; sb = 2'b11; ao = 3'b001; alo = 1; end
      8'd5:  begin
        sa = 1;
        if (fn == 6'h20)      begin ao = 3'b001; alo = 1; end
        else if (fn == 6'h22) begin ao = 3'b010; alo = 1; end
        else if (fn == 6'h24) begin ao = 3'b011; alo = 1; end
      end
      8'd6:  begin rw = 1; rd = 1; end
      8'd7:  begin sa = 1; sb = 2'b10; ao = 3'b001; alo = 1; end
      8'd8, 8'd9: id = 1;
      8'd10: begin id = 1; mdr = 1; end
      8'd11: begin rw = 1; m2r = 1; end
      8'd12: begin id = 1; w = 1; end
      8'd13: begin sa = 1; ao = 3'b010; ps = 2'b01; pl = (op == 6'h05) ? ~z : z; end
      8'd14: begin ps = 2'b10; pl = 1; end
      8'd15: begin sa = 1; sb = 2'b10; ao = 3'b001; alo = 1; end
      8'd16: rw = 1;
      8'd17: begin sb = 2'b01; ao = 3'b010; epc = 1; end
      8'd18: begin ps = 2'b11; pl = 1; end
      default: ;
    endcase
    return {st, pl, id, w, irw, mdr, ab, alo, epc, rw, rd, m2r, sa, sb, ao, ps};
  endfunction

  // Called at a negedge with the DUT in FETCH1; returns at the next FETCH1 negedge.
  task automatic run_instr(input string name, input logic [5:0] op, input logic [5:0] fn,
                           input logic z, input logic ov);
    logic [7:0] st;
    opcode = op;
    funct  = fn;
    foreach (seq_q[i]) exp_q.push_back(exp_vec(seq_q[i], op, fn, z));
    for (int i = 0; i < seq_q.size(); i++) begin
      st = seq_q[i];
      zero     = (st == 8'd13) ? z : 1'($urandom_range(0, 1));
      overflow = (st == 8'd5 || st == 8'd15) ? ov : 1'($urandom_range(0, 1));
      #1;
      check($sformatf("%s/st%0d", name, st), dut_vec(), exp_q.pop_front());
      @(negedge clk);
    end
  endtask

  task automatic run_kind(input int k);
    logic [5:0] rfn;
    rfn = 6'($urandom_range(0, 63));
    case (k)
      0:  begin seq_q = '{1, 2, 3, 4, 5, 6};        run_instr("add",     6'h00, 6'h20, 0, 0); end
      1:  begin seq_q = '{1, 2, 3, 4, 5, 6};        run_instr("sub",     6'h00, 6'h22, 0, 0); end
      2:  begin seq_q = '{1, 2, 3, 4, 5, 6};        run_instr("and_ov",  6'h00, 6'h24, 0, 1); end
      3:  begin seq_q = '{1, 2, 3, 4, 5, 17, 18};   run_instr("add_ov",  6'h00, 6'h20, 0, 1); end
      4:  begin seq_q = '{1, 2, 3, 4, 5, 17, 18};   run_instr("sub_ov",  6'h00, 6'h22, 0, 1); end
      5:  begin seq_q = '{1, 2, 3, 4, 5, 17, 18};   run_instr("bad_fn",  6'h00, 6'h2A, 0, 0); end
      6:  begin seq_q = '{1, 2, 3, 4, 7, 8, 9, 10, 11}; run_instr("lw",  6'h23, rfn, 0, 0); end
      7:  begin seq_q = '{1, 2, 3, 4, 7, 12};       run_instr("sw",      6'h2B, rfn, 0, 0); end
      8:  begin seq_q = '{1, 2, 3, 4, 13};          run_instr("beq_z1",  6'h04, rfn, 1, 0); end
      9:  begin seq_q = '{1, 2, 3, 4, 13};          run_instr("beq_z0",  6'h04, rfn, 0, 0); end
      10: begin seq_q = '{1, 2, 3, 4, 13};          run_instr("bne_z0",  6'h05, rfn, 0, 0); end
      11: begin seq_q = '{1, 2, 3, 4, 13};          run_instr("bne_z1",  6'h05, rfn, 1, 0); end
      12: begin seq_q = '{1, 2, 3, 4, 14};          run_instr("j",       6'h02, rfn, 0, 0); end
      13: begin seq_q = '{1, 2, 3, 4, 15, 16};      run_instr("addi",    6'h08, rfn, 0, 0); end
      14: begin seq_q = '{1, 2, 3, 4, 15, 17, 18};  run_instr("addi_ov", 6'h08, rfn, 0, 1); end
      default: begin seq_q = '{1, 2, 3, 4, 17, 18}; run_instr("bad_op",  6'h3F, rfn, 0, 0); end
    endcase
  endtask

  initial begin
    rst = 1'b1; opcode = '0; funct = '0; zero = 1'b0; overflow = 1'b0;
    repeat (2) @(negedge clk);
    #1 check("reset_hold", dut_vec(), exp_vec(8'd0, 6'h00, 6'h00, 1'b0));
    rst = 1'b0;
    @(negedge clk);

    for (int k = 0; k < 16; k++) run_kind(k);

    // Asynchronous reset in the middle of FETCH2.
    seq_q = '{1};
    run_instr("pre_rst", 6'h00, 6'h20, 0, 0);
    #1 check("in_fetch2", dut_vec(), exp_vec(8'd2, 6'h00, 6'h20, 1'b0));
    #2 rst = 1'b1;
    #1 check("rst_async", dut_vec(), exp_vec(8'd0, 6'h00, 6'h20, 1'b0));
    @(negedge clk);
    #1 check("rst_held", dut_vec(), exp_vec(8'd0, 6'h00, 6'h20, 1'b0));
    rst = 1'b0;
    @(negedge clk);
    run_kind(0);

    for (int i = 0; i < 30; i++) run_kind($urandom_range(0, 15));

    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL exp_q_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
